// File: rtl/dmux_stream_pkg.sv
// Shared defaults for the registered stream demultiplexer and its bench.
package dmux_stream_pkg;

   localparam int DMUX_WIDTH_DEF = 16;
   localparam int DMUX_SEL_W_DEF = 3;
   localparam int DMUX_CNT_W_DEF = 16;

endpackage

// File: rtl/dmux_stream_decoder.sv
// Combinational lane select: sel -> N-bit one-hot mask (generalised DMux8Way decode).
module onehot_decoder #(
   parameter int SEL_W = 3
) (
   input  logic [SEL_W-1:0]      sel,
   output logic [(1<<SEL_W)-1:0] mask
);

   always_comb begin
      mask      = '0;
      mask[sel] = 1'b1;
   end

endmodule

// File: rtl/dmux_stream.sv
// Registered 1-to-N demultiplexer with per-lane valid/ready and broadcast.
// One word is held at a time; each lane clears its pending bit independently.
module dmux_stream
   import dmux_stream_pkg::*;
#(
   parameter int WIDTH = DMUX_WIDTH_DEF,
   parameter int SEL_W = DMUX_SEL_W_DEF,
   parameter int CNT_W = DMUX_CNT_W_DEF
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_bcast,
   input  logic                   flush,
   output logic [WIDTH-1:0]       out_data,
   output logic [(1<<SEL_W)-1:0]  out_valid,
   input  logic [(1<<SEL_W)-1:0]  out_ready,
   output logic [CNT_W-1:0]       xfer_cnt
);

   localparam int N = 1 << SEL_W;

   logic [WIDTH-1:0] data_q;
   logic [N-1:0]     pend;
   logic [N-1:0]     sel_mask;
   logic             accept;

   onehot_decoder #(.SEL_W(SEL_W)) u_dec (
      .sel  (in_sel),
      .mask (sel_mask)
   );

   // Ready as soon as every still-pending lane is completing this cycle.
   assign in_ready  = ((pend & ~out_ready) == '0) && !flush;
   assign accept    = in_valid && in_ready;
   assign out_valid = pend;
   assign out_data  = data_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_q   <= '0;
         pend     <= '0;
         xfer_cnt <= '0;
      end else if (flush) begin
         pend <= '0;
      end else if (accept) begin
         data_q   <= in_data;
         pend     <= in_bcast ? {N{1'b1}} : sel_mask;
         xfer_cnt <= xfer_cnt + CNT_W'(1);
      end else begin
         pend <= pend & ~out_ready;
      end
   end

endmodule
